c17_pipe: RTL and testbench
===========================

Name: c17_pipe

Overview:
- Bit-level pipelined version of the ISCAS-85 c17 benchmark: six 2-input NAND gates in three logic levels, five inputs (N1, N2, N3, N6, N7), two outputs (N22, N23).
- A register bank follows each logic level, so one new input vector is accepted every clock.
- Used as the reference datapath block for bit-level pipelining experiments.
- A valid bit travels alongside the data; a clock enable stalls the whole pipe.

Parameters:
- REG_INPUTS, 0, when 1 adds an input register stage before level 1 (latency 3 -> 4).

Ports:
- clk  input  1  single rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  clock enable; 0 freezes every pipeline register
- in_valid  input  1  the current N1..N7 vector is meaningful
- N1  input  1  c17 primary input
- N2  input  1  c17 primary input
- N3  input  1  c17 primary input
- N6  input  1  c17 primary input
- N7  input  1  c17 primary input
- N22  output  1  c17 primary output (registered)
- N23  output  1  c17 primary output (registered)
- out_valid  output  1  N22/N23 correspond to a vector accepted with in_valid=1

Behaviour:
- Logic function (must match bit-exactly):
  - N10=NAND(N1,N3), N11=NAND(N3,N6)
  - N16=NAND(N2,N11), N19=NAND(N11,N7)
  - N22=NAND(N10,N16), N23=NAND(N16,N19)
- Stage 1 register: N10, N11, plus pass-through copies of N2 and N7, plus v1.
- Stage 2 register: N16, N19, plus pass-through copy of N10, plus v2.
- Stage 3 register: N22, N23, out_valid. These register outputs drive the ports directly; no combinational path from any input to any output.
- Latency:
  - REG_INPUTS=0: a vector sampled at edge k appears on N22/N23 after edge k+2, i.e. 3 enabled edges including the sampling edge.
  - REG_INPUTS=1: one extra enabled edge.
  - Throughput is one vector per enabled clock.
- Reset: rst=1 asynchronously clears every pipeline register, including the input stage, all pass-through bits and all valid bits. N22=0, N23=0 and out_valid=0 while in reset. Reset mid-stream discards all in-flight vectors; the first output after release is valid only once a new in_valid vector has traversed the pipe.
- en=0: all registers hold, outputs are stable, and inputs presented during the stall are ignored. en=1 resumes with no loss or duplication.
- in_valid=0: data still propagates, with no gating of data registers. The corresponding out_valid is 0. Downstream logic must qualify N22/N23 with out_valid.
- rst takes priority over en.
- X on inputs while in_valid=0 must not corrupt valid results.

Decomposition:
- Shared package c17_pkg:
  - constant C17_LATENCY = 3 + REG_INPUTS (expressed as a function of the parameter)
  - packed struct typedefs for stage-1 and stage-2 register contents
- One natural sub-module: c17_stage_reg, a parameterised-width register with async active-high reset and enable, instantiated once per stage.
- The NAND logic stays inline.

Test Plan:
- Reset then single vector N1..N7=1,0,1,0,1 with in_valid=1, en=1 -> after 3 edges N22=1, N23=1, out_valid=1 for exactly one cycle.
- Back-to-back stream, one vector per cycle:
  - 0,1,0,1,0 -> 1,1
  - 1,0,0,1,1 -> 0,1
  - 1,1,0,0,0 -> 1,1
  - 0,1,1,0,1 -> 1,1
  - 1,1,1,1,1 -> 1,0
  - 0,0,0,0,0 -> 0,0
  - Each result appears 3 cycles after its input, consecutive cycles, out_valid=1 throughout.
- Stall: stream three vectors, drop en for 4 cycles mid-flight while toggling inputs -> outputs frozen, then remaining results emerge in order with no duplicates.
- Async reset asserted between clock edges with the pipe full -> N22, N23 and out_valid go to 0 immediately; after release, out_valid stays 0 until a new vector completes.
- Exhaustive: all 32 input combinations streamed with in_valid=1 -> every output matches the NAND equations 3 cycles later. Repeat with REG_INPUTS=1 at latency 4.
- in_valid gaps: alternate in_valid 1/0 -> out_valid reproduces the pattern delayed by 3 cycles.

Source files
------------

// File: rtl/c17_pkg.sv
// Shared types and latency helper for the bit-level pipelined ISCAS-85 c17 block.
package c17_pkg;

    localparam int C17_BASE_LATENCY = 3;

    typedef struct packed {
        logic n1;
        logic n2;
        logic n3;
        logic n6;
        logic n7;
        logic v;
    } in_t;

    typedef struct packed {
        logic n10;
        logic n11;
        logic n2;
        logic n7;
        logic v;
    } stage1_t;

    typedef struct packed {
        logic n16;
        logic n19;
        logic n10;
        logic v;
    } stage2_t;

    typedef struct packed {
        logic n22;
        logic n23;
        logic v;
    } stage3_t;

    // Enabled edges from sampling a vector to seeing its result on the ports.
    function automatic int c17_latency(input int reg_inputs);
        return C17_BASE_LATENCY + ((reg_inputs != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/c17_stage_reg.sv
// Generic pipeline register with asynchronous active-high clear and clock enable.
module c17_stage_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Hold when disabled; reset wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/c17_pipe.sv
// c17 benchmark split into three NAND levels, each followed by a register bank,
// with an optional input register and a valid bit riding along with the data.
module c17_pipe
    import c17_pkg::*;
#(
    parameter int REG_INPUTS = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in_valid,
    input  logic N1,
    input  logic N2,
    input  logic N3,
    input  logic N6,
    input  logic N7,
    output logic N22,
    output logic N23,
    output logic out_valid
);

    localparam int C17_LATENCY  = c17_latency(REG_INPUTS);
    localparam bit HAS_IN_STAGE = (C17_LATENCY > C17_BASE_LATENCY);

    in_t     in_d;
    in_t     in_q;
    stage1_t s1_d;
    stage1_t s1_q;
    stage2_t s2_d;
    stage2_t s2_q;
    stage3_t s3_d;
    stage3_t s3_q;

    // Gather the primary inputs; data is never gated by in_valid.
    always_comb begin
        in_d    = '0;
        in_d.n1 = N1;
        in_d.n2 = N2;
        in_d.n3 = N3;
        in_d.n6 = N6;
        in_d.n7 = N7;
        in_d.v  = in_valid;
    end

    generate
        if (HAS_IN_STAGE) begin : g_in_reg
            c17_stage_reg #(.WIDTH($bits(in_t))) u_in_reg (
                .clk  (clk),
                .rst  (rst),
                .en_i (en),
                .d_i  (in_d),
                .q_o  (in_q)
            );
        end else begin : g_in_comb
            assign in_q = in_d;
        end
    endgenerate

    // Level 1 NANDs, N2/N7 carried forward for level 2.
    always_comb begin
        s1_d     = '0;
        s1_d.n10 = ~(in_q.n1 & in_q.n3);
        s1_d.n11 = ~(in_q.n3 & in_q.n6);
        s1_d.n2  = in_q.n2;
        s1_d.n7  = in_q.n7;
        s1_d.v   = in_q.v;
    end

    c17_stage_reg #(.WIDTH($bits(stage1_t))) u_s1_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (en),
        .d_i  (s1_d),
        .q_o  (s1_q)
    );

    // Level 2 NANDs, N10 carried forward for level 3.
    always_comb begin
        s2_d     = '0;
        s2_d.n16 = ~(s1_q.n2 & s1_q.n11);
        s2_d.n19 = ~(s1_q.n11 & s1_q.n7);
        s2_d.n10 = s1_q.n10;
        s2_d.v   = s1_q.v;
    end

    c17_stage_reg #(.WIDTH($bits(stage2_t))) u_s2_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (en),
        .d_i  (s2_d),
        .q_o  (s2_q)
    );

    // Level 3 NANDs producing the primary outputs.
    always_comb begin
        s3_d     = '0;
        s3_d.n22 = ~(s2_q.n10 & s2_q.n16);
        s3_d.n23 = ~(s2_q.n16 & s2_q.n19);
        s3_d.v   = s2_q.v;
    end

    c17_stage_reg #(.WIDTH($bits(stage3_t))) u_s3_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (en),
        .d_i  (s3_d),
        .q_o  (s3_q)
    );

    assign N22       = s3_q.n22;
    assign N23       = s3_q.n23;
    assign out_valid = s3_q.v;

endmodule

// File: tb/tb_c17_pipe.sv
// Directed bench for c17_pipe: latency-3 and latency-4 builds driven by the same stimulus.
module tb_c17_pipe;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic in_valid;
    logic n1, n2, n3, n6, n7;
    logic o22_a, o23_a, ov_a;
    logic o22_b, o23_b, ov_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    c17_pipe #(.REG_INPUTS(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
        .N22(o22_a), .N23(o23_a), .out_valid(ov_a)
    );

    c17_pipe #(.REG_INPUTS(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
        .N22(o22_b), .N23(o23_b), .out_valid(ov_b)
    );

    // Sum-of-products form of c17, vector bits ordered {N1,N2,N3,N6,N7}.
    function automatic logic [1:0] ref_out(input logic [4:0] vec);
        logic a, b, c, d, e;
        {a, b, c, d, e} = vec;
        return {(a & c) | (b & ~(c & d)), ~(c & d) & (b | e)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] vec);
        in_valid = v;
        {n1, n2, n3, n6, n7} = vec;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [4:0] s_vec [6] = '{5'b01010, 5'b10011, 5'b11000, 5'b01101, 5'b11111, 5'b00000};
    logic [1:0] s_exp [6] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
    logic       gap_v   [12];
    logic [4:0] gap_vec [12];

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        drive(1'b1, 5'b11111);
        #6;
        chk("reset_a", {o22_a, o23_a, ov_a}, 3'b000);
        chk("reset_b", {o22_b, o23_b, ov_b}, 3'b000);
        #6;
        drive(1'b0, 5'b00000);
        rst = 1'b0;

        // single vector 1,0,1,0,1 -> 1,1
        step();
        drive(1'b1, 5'b10101);
        step();
        drive(1'b0, 5'bxxxxx);
        step();
        chk("single_early_a", {2'b00, ov_a}, 3'b000);
        step();
        chk("single_a", {o22_a, o23_a, ov_a}, 3'b111);
        step();
        chk("single_after_a", {2'b00, ov_a}, 3'b000);
        chk("single_b", {o22_b, o23_b, ov_b}, 3'b111);
        step();
        chk("single_after_b", {2'b00, ov_b}, 3'b000);

        // back-to-back stream, hand-computed results
        for (int i = 0; i < 10; i++) begin
            if (i < 6) drive(1'b1, s_vec[i]);
            else       drive(1'b0, 5'bxxxxx);
            step();
            if (i >= 2 && i < 8)
                chk($sformatf("stream_a[%0d]", i - 2), {o22_a, o23_a, ov_a}, {s_exp[i - 2], 1'b1});
            else if (i == 8)
                chk("stream_drain_a", {2'b00, ov_a}, 3'b000);
            if (i >= 3 && i < 9)
                chk($sformatf("stream_b[%0d]", i - 3), {o22_b, o23_b, ov_b}, {s_exp[i - 3], 1'b1});
            else if (i == 9)
                chk("stream_drain_b", {2'b00, ov_b}, 3'b000);
        end

        // stall mid-flight: 10101->11, 10011->01, 11111->10
        drive(1'b1, 5'b10101); step();
        drive(1'b1, 5'b10011); step();
        drive(1'b1, 5'b11111); step();
        chk("stall_pre_a", {o22_a, o23_a, ov_a}, 3'b111);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            step();
            chk($sformatf("stall_hold_a[%0d]", i), {o22_a, o23_a, ov_a}, 3'b111);
            chk($sformatf("stall_hold_b[%0d]", i), {2'b00, ov_b}, 3'b000);
        end
        drive(1'b0, 5'bxxxxx);
        en = 1'b1;
        step();
        chk("stall_r1_a", {o22_a, o23_a, ov_a}, 3'b011);
        chk("stall_r0_b", {o22_b, o23_b, ov_b}, 3'b111);
        step();
        chk("stall_r2_a", {o22_a, o23_a, ov_a}, 3'b101);
        chk("stall_r1_b", {o22_b, o23_b, ov_b}, 3'b011);
        step();
        chk("stall_end_a", {2'b00, ov_a}, 3'b000);
        chk("stall_r2_b", {o22_b, o23_b, ov_b}, 3'b101);
        step();
        chk("stall_end_b", {2'b00, ov_b}, 3'b000);

        // async reset with a full pipe, asserted and released between edges
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, s_vec[i]);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_a", {o22_a, o23_a, ov_a}, 3'b000);
        chk("async_rst_b", {o22_b, o23_b, ov_b}, 3'b000);
        drive(1'b0, 5'bxxxxx);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_rst_a[%0d]", i), {2'b00, ov_a}, 3'b000);
            chk($sformatf("post_rst_b[%0d]", i), {2'b00, ov_b}, 3'b000);
        end
        drive(1'b1, 5'b01010);
        step();
        drive(1'b0, 5'bxxxxx);
        step();
        step();
        chk("post_rst_vec_a", {o22_a, o23_a, ov_a}, 3'b111);
        step();
        chk("post_rst_vec_b", {o22_b, o23_b, ov_b}, 3'b111);

        // exhaustive 32 combinations, both latencies
        for (int i = 0; i < 35; i++) begin
            if (i < 32) drive(1'b1, 5'(i));
            else        drive(1'b0, 5'bxxxxx);
            step();
            if (i >= 2 && i < 34)
                chk($sformatf("exh_a[%0d]", i - 2), {o22_a, o23_a, ov_a}, {ref_out(5'(i - 2)), 1'b1});
            if (i >= 3)
                chk($sformatf("exh_b[%0d]", i - 3), {o22_b, o23_b, ov_b}, {ref_out(5'(i - 3)), 1'b1});
        end
        step();
        chk("exh_drain_a", {2'b00, ov_a}, 3'b000);
        chk("exh_drain_b", {2'b00, ov_b}, 3'b000);

        // alternating in_valid gaps with X data on the idle slots
        for (int i = 0; i < 12; i++) begin
            gap_v[i]   = ~i[0];
            gap_vec[i] = 5'((i * 7) + 3);
        end
        for (int i = 0; i < 15; i++) begin
            if (i < 12 && gap_v[i]) drive(1'b1, gap_vec[i]);
            else                    drive(1'b0, 5'bxxxxx);
            step();
            if (i >= 2 && i < 14) begin
                if (gap_v[i - 2])
                    chk($sformatf("gap_a[%0d]", i - 2), {o22_a, o23_a, ov_a}, {ref_out(gap_vec[i - 2]), 1'b1});
                else
                    chk($sformatf("gap_a[%0d]", i - 2), {2'b00, ov_a}, 3'b000);
            end
            if (i >= 3) begin
                if (gap_v[i - 3])
                    chk($sformatf("gap_b[%0d]", i - 3), {o22_b, o23_b, ov_b}, {ref_out(gap_vec[i - 3]), 1'b1});
                else
                    chk($sformatf("gap_b[%0d]", i - 3), {2'b00, ov_b}, 3'b000);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
